// File: rtl/fetch_stall_gen.sv
// Instruction fetch front end: drives a single outstanding AR/R read per PC,
// stalls the core until the response lands and holds completion under hazards.
module fetch_stall_gen #(
   parameter int DATA_SIZE = 32,
   parameter int CNT_SIZE  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] pc,
   input  logic                 hazard_stall,
   output logic [DATA_SIZE-1:0] araddr,
   output logic                 arvalid,
   input  logic                 arready,
   input  logic                 rvalid,
   input  logic [DATA_SIZE-1:0] rdata,
   output logic                 rready,
   output logic                 bus_stall,
   output logic                 instruction_stall,
   output logic [DATA_SIZE-1:0] past_pc,
   output logic [DATA_SIZE-1:0] instr,
   output logic                 instr_valid,
   output logic [CNT_SIZE-1:0]  stall_cycles
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [DATA_SIZE-1:0] NOP_INSTR = DATA_SIZE'(32'h0000_0013);
   localparam logic [CNT_SIZE-1:0]  CNT_MAX   = '1;

   state_t                 state_q, state_d;
   logic [DATA_SIZE-1:0]   addr_q, addr_d;
   logic [DATA_SIZE-1:0]   past_pc_q, past_pc_d;
   logic [DATA_SIZE-1:0]   instr_q, instr_d;
   logic                   instr_valid_q, instr_valid_d;
   logic [CNT_SIZE-1:0]    stall_cycles_q, stall_cycles_d;

   logic                   fetch_done;
   logic                   enter_ar;

   // The response is only ever taken in R; rvalid elsewhere is deliberately ignored.
   assign fetch_done = (state_q == R) && rvalid;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: state_d = AR;
         AR: begin
            if (arready) begin
               state_d = R;
            end
         end
         R: begin
            if (rvalid) begin
               state_d = hazard_stall ? HOLD : AR;
            end
         end
         HOLD: begin
            if (!hazard_stall) begin
               state_d = AR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The PC is captured only on the edge that enters AR, so it stays frozen for the whole request.
   assign enter_ar = (state_d == AR) && (state_q != AR);

   always_comb begin
      addr_d         = addr_q;
      past_pc_d      = past_pc_q;
      instr_d        = instr_q;
      instr_valid_d  = 1'b0;
      stall_cycles_d = stall_cycles_q;

      if (enter_ar) begin
         addr_d = pc;
      end

      if (fetch_done) begin
         instr_d       = rdata;
         past_pc_d     = addr_q;
         instr_valid_d = 1'b1;
      end

      if (bus_stall && (stall_cycles_q != CNT_MAX)) begin
         stall_cycles_d = stall_cycles_q + CNT_SIZE'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         past_pc_q      <= '0;
         instr_q        <= NOP_INSTR;
         instr_valid_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         past_pc_q      <= past_pc_d;
         instr_q        <= instr_d;
         instr_valid_q  <= instr_valid_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign araddr            = {addr_q[DATA_SIZE-1:2], 2'b00};
   assign arvalid           = (state_q == AR);
   assign rready            = (state_q == R);
   assign bus_stall         = !fetch_done;
   assign instruction_stall = (state_q == HOLD) || hazard_stall;
   assign past_pc           = past_pc_q;
   assign instr             = instr_q;
   assign instr_valid       = instr_valid_q;
   assign stall_cycles      = stall_cycles_q;

endmodule

// File: tb/tb_fetch_stall_gen.sv
// Bench for fetch_stall_gen: plays the instruction memory on a planned timeline
// and checks every cycle against a transaction-level expectation.
module tb_fetch_stall_gen;

   localparam int DS   = 32;
   localparam int CNT  = 10;
   localparam int MAXC = (1 << CNT) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic [DS-1:0]   pc;
   logic            hazard_stall;
   logic [DS-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic            rvalid;
   logic [DS-1:0]   rdata;
   logic            rready;
   logic            bus_stall;
   logic            instruction_stall;
   logic [DS-1:0]   past_pc;
   logic [DS-1:0]   instr;
   logic            instr_valid;
   logic [CNT-1:0]  stall_cycles;

   fetch_stall_gen #(.DATA_SIZE(DS), .CNT_SIZE(CNT)) dut (
      .clk               (clk),
      .rst               (rst),
      .pc                (pc),
      .hazard_stall      (hazard_stall),
      .araddr            (araddr),
      .arvalid           (arvalid),
      .arready           (arready),
      .rvalid            (rvalid),
      .rdata             (rdata),
      .rready            (rready),
      .bus_stall         (bus_stall),
      .instruction_stall (instruction_stall),
      .past_pc           (past_pc),
      .instr             (instr),
      .instr_valid       (instr_valid),
      .stall_cycles      (stall_cycles)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   // Every clock edge since reset is a stall cycle except the ones that complete a fetch.
   int            edges    = 0;
   int            done_cnt = 0;
   logic          exp_valid;
   logic [DS-1:0] exp_instr;
   logic [DS-1:0] exp_past;
   logic [DS-1:0] cur_pc;

   function automatic logic [CNT-1:0] exp_stall();
      int v;
      v = edges - done_cnt;
      if (v > MAXC) v = MAXC;
      return CNT'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      edges++;
      @(negedge clk);
   endtask

   // Called at a negedge; leaves the DUT in its first AR cycle with addr captured from entry_pc.
   task automatic do_reset(input logic [DS-1:0] entry_pc);
      rst = 1'b1; hazard_stall = 1'b0; arready = $urandom; rvalid = $urandom;
      rdata = $urandom; pc = $urandom;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if ({arvalid, rready, bus_stall, instruction_stall, instr_valid} !== 5'b00100) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00100",
                  {arvalid, rready, bus_stall, instruction_stall, instr_valid});
      end
      n_checks++;
      if ({instr, past_pc, stall_cycles} !== {32'h0000_0013, 32'h0, CNT'(0)}) begin
         n_fail++;
         $display("FAIL reset_regs: instr=%h past_pc=%h stall=%0d want 00000013/0/0",
                  instr, past_pc, stall_cycles);
      end
      rst = 1'b0; pc = entry_pc;
      edges = 0; done_cnt = 0;
      exp_valid = 1'b0; exp_instr = 32'h0000_0013; exp_past = '0;
      #1;
      n_checks++;
      if ({arvalid, rready, bus_stall, instr_valid} !== 4'b0010) begin
         n_fail++;
         $display("FAIL idle_ctrl: got %b want 0010", {arvalid, rready, bus_stall, instr_valid});
      end
      tick();
   endtask

   // One complete fetch from its first AR cycle; next_pc is presented on the cycle that leads into the next AR.
   task automatic fetch(input logic [DS-1:0] entry_pc, input int ar_wait, input int r_wait,
                        input int hz_len, input logic [DS-1:0] next_pc,
                        input logic [DS-1:0] data, input string name);
      int  f0;
      bit  last;
      f0 = n_fail;
      for (int i = 0; i <= ar_wait; i++) begin
         arready = (i == ar_wait); rvalid = $urandom; hazard_stall = $urandom;
         pc = $urandom; rdata = $urandom;
         #1;
         n_checks++;
         if ({arvalid, rready, bus_stall, instruction_stall, instr_valid} !==
             {1'b1, 1'b0, 1'b1, hazard_stall, exp_valid}) begin
            n_fail++;
            $display("FAIL %s ar_ctrl cyc%0d: got %b want %b", name, i,
                     {arvalid, rready, bus_stall, instruction_stall, instr_valid},
                     {1'b1, 1'b0, 1'b1, hazard_stall, exp_valid});
         end
         n_checks++;
         if (araddr !== {entry_pc[DS-1:2], 2'b00}) begin
            n_fail++;
            $display("FAIL %s araddr cyc%0d: got %h want %h", name, i, araddr,
                     {entry_pc[DS-1:2], 2'b00});
         end
         n_checks++;
         if (stall_cycles !== exp_stall()) begin
            n_fail++;
            $display("FAIL %s stall_ar cyc%0d: got %0d want %0d", name, i, stall_cycles, exp_stall());
         end
         n_checks++;
         if ({instr, past_pc} !== {exp_instr, exp_past}) begin
            n_fail++;
            $display("FAIL %s held_regs: instr=%h past_pc=%h want %h/%h", name, instr, past_pc,
                     exp_instr, exp_past);
         end
         exp_valid = 1'b0;
         tick();
      end
      for (int j = 0; j <= r_wait; j++) begin
         last = (j == r_wait);
         rvalid = last; arready = $urandom;
         hazard_stall = last ? (hz_len > 0) : 1'($urandom);
         pc = (last && hz_len == 0) ? next_pc : DS'($urandom);
         rdata = last ? data : DS'($urandom);
         #1;
         n_checks++;
         if ({arvalid, rready, bus_stall, instruction_stall, instr_valid} !==
             {1'b0, 1'b1, !last, hazard_stall, 1'b0}) begin
            n_fail++;
            $display("FAIL %s r_ctrl cyc%0d: got %b want %b", name, j,
                     {arvalid, rready, bus_stall, instruction_stall, instr_valid},
                     {1'b0, 1'b1, !last, hazard_stall, 1'b0});
         end
         n_checks++;
         if (stall_cycles !== exp_stall()) begin
            n_fail++;
            $display("FAIL %s stall_r cyc%0d: got %0d want %0d", name, j, stall_cycles, exp_stall());
         end
         if (last) done_cnt++;
         tick();
      end
      exp_instr = data; exp_past = entry_pc; exp_valid = 1'b1;
      for (int h = 1; h <= hz_len; h++) begin
         last = (h == hz_len);
         hazard_stall = !last; pc = last ? next_pc : DS'($urandom);
         rvalid = $urandom; arready = $urandom; rdata = $urandom;
         #1;
         n_checks++;
         if ({arvalid, rready, bus_stall, instruction_stall, instr_valid} !==
             {1'b0, 1'b0, 1'b1, 1'b1, exp_valid}) begin
            n_fail++;
            $display("FAIL %s hold_ctrl cyc%0d: got %b want %b", name, h,
                     {arvalid, rready, bus_stall, instruction_stall, instr_valid},
                     {1'b0, 1'b0, 1'b1, 1'b1, exp_valid});
         end
         n_checks++;
         if ({instr, past_pc} !== {exp_instr, exp_past}) begin
            n_fail++;
            $display("FAIL %s hold_regs: instr=%h past_pc=%h want %h/%h", name, instr, past_pc,
                     exp_instr, exp_past);
         end
         exp_valid = 1'b0;
         tick();
      end
      $display("fetch %-8s pc=%h ar_wait=%0d r_wait=%0d hold=%0d data=%h : %s", name, entry_pc,
               ar_wait, r_wait, hz_len, data, (n_fail == f0) ? "ok" : "errors");
   endtask

   task automatic test_reset();
      do_reset(32'h100);
      cur_pc = 32'h100;
   endtask

   task automatic test_basic();
      fetch(32'h100, 0, 0, 0, 32'h200, 32'hdead_beef, "basic");
   endtask

   task automatic test_ar_wait();
      fetch(32'h200, 3, 0, 0, 32'h103, 32'h1234_5678, "ar_wait");
   endtask

   task automatic test_unaligned();
      fetch(32'h103, 0, 1, 0, 32'h400, 32'h0bad_f00d, "unalign");
   endtask

   task automatic test_hazard();
      fetch(32'h400, 1, 0, 2, 32'h500, 32'h0000_0533, "hazard");
      fetch(32'h500, 0, 2, 1, 32'h504, 32'h0000_0633, "hazard1");
      cur_pc = 32'h504;
   endtask

   task automatic test_back_to_back();
      logic [DS-1:0] nxt;
      for (int k = 0; k < 40; k++) begin
         nxt = $urandom;
         fetch(cur_pc, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               nxt, $urandom, "random");
         cur_pc = nxt;
      end
   endtask

   task automatic test_reset_mid();
      fetch(cur_pc, 0, 0, 0, 32'h300, 32'hcafe_0001, "pre_rst");
      arready = 1'b1; rvalid = 1'b0; hazard_stall = 1'b0;
      tick();
      rvalid = 1'b0; rst = 1'b1;
      #1;
      n_checks++;
      if (rready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_rst_in_r: rready=%b want 1", rready);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if ({arvalid, rready, instr, past_pc, stall_cycles} !==
          {1'b0, 1'b0, 32'h0000_0013, 32'h0, CNT'(0)}) begin
         n_fail++;
         $display("FAIL mid_rst: arvalid=%b rready=%b instr=%h past_pc=%h stall=%0d want 0/0/00000013/0/0",
                  arvalid, rready, instr, past_pc, stall_cycles);
      end
      $display("reset mid-transaction in R checked");
      do_reset(32'h600);
   endtask

   task automatic test_saturate();
      fetch(32'h600, MAXC + 6, 0, 0, 32'h700, 32'h5a5a_5a5a, "saturate");
      n_checks++;
      if (stall_cycles !== CNT'(MAXC)) begin
         n_fail++;
         $display("FAIL saturate_end: got %0d want %0d", stall_cycles, MAXC);
      end
      fetch(32'h700, 0, 0, 0, 32'h800, 32'h0000_0113, "post_sat");
   endtask

   initial begin
      rst = 1'b1; pc = '0; hazard_stall = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_ar_wait();
      test_unaligned();
      test_hazard();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
